// File: rtl/laser_safety_pkg.sv
// Shared definitions for the laser safety supervisor: state encodings,
// fault_code bit positions and power-on limit values.
package laser_safety_pkg;

  typedef enum logic [2:0] {
    ST_SAFE     = 3'd0,
    ST_ARMING   = 3'd1,
    ST_ARMED    = 3'd2,
    ST_FAULT    = 3'd3,
    ST_CLEARING = 3'd4,
    ST_LOCKOUT  = 3'd5
  } ctrl_state_e;

  localparam int FC_LOWER = 0;
  localparam int FC_UPPER = 1;
  localparam int FC_RATE  = 2;

  localparam logic [31:0] WLO_DEF_C = 32'h307;
  localparam logic [31:0] WHI_DEF_C = 32'h314;
  localparam logic [31:0] RLO_DEF_C = 32'h1312D;

endpackage

// File: rtl/laser_safety_ctrl_timer.sv
// Loadable 32-bit down-counter with a zero flag; it holds at zero and is
// shared by the ARMING delay and the CLEARING hold.
module safety_timer (
  input  logic        clk,
  input  logic        rstn,
  input  logic        load,
  input  logic        dec,
  input  logic [31:0] load_val,
  output logic        zero
);

  logic [31:0] count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != 32'd0)) begin
      count_reg <= count_reg - 32'd1;
    end
  end

  assign zero = (count_reg == 32'd0);

endmodule

// File: rtl/laser_safety_ctrl.sv
// Arm/disarm supervisor for the pulse checker: owns the limit registers,
// gates laser_ready, latches fault flags and runs the clear_fail handshake.
module laser_safety_ctrl
  import laser_safety_pkg::*;
#(
  parameter int          ARM_DELAY  = 1000,
  parameter int          CLEAR_HOLD = 16,
  parameter int          MAX_FAULTS = 3,
  parameter logic [31:0] WLO_DEF    = WLO_DEF_C,
  parameter logic [31:0] WHI_DEF    = WHI_DEF_C,
  parameter logic [31:0] RLO_DEF    = RLO_DEF_C
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        arm_req,
  input  logic        disarm_req,
  input  logic        fault_ack,
  input  logic        cfg_load,
  input  logic [31:0] cfg_wlo,
  input  logic [31:0] cfg_whi,
  input  logic [31:0] cfg_rlo,
  input  logic        pulse_lower_limit_fail,
  input  logic        pulse_upper_limit_fail,
  input  logic        rate_lower_limit_fail,
  output logic [31:0] pulse_width_lower_limit,
  output logic [31:0] pulse_width_upper_limit,
  output logic [31:0] rate_lower_limit,
  output logic        laser_ready,
  output logic        clear_fail,
  output logic [2:0]  ctrl_state,
  output logic [2:0]  fault_code,
  output logic [1:0]  fault_count,
  output logic        lockout,
  output logic        cfg_err
);

  ctrl_state_e state_reg;
  logic [2:0]  fault_code_reg;
  logic [1:0]  fault_count_reg;
  logic        laser_ready_reg, clear_fail_reg, lockout_reg, cfg_err_reg;
  logic [31:0] wlo_reg, whi_reg, rlo_reg;

  logic [2:0]  fail_vec;
  logic        fail_any, arm_go, ack_go, tmr_zero, tmr_load, tmr_dec, cfg_ok;
  logic [1:0]  count_next;
  logic [31:0] tmr_val;
  ctrl_state_e fault_dest;

  always_comb begin
    fail_vec           = '0;
    fail_vec[FC_LOWER] = pulse_lower_limit_fail;
    fail_vec[FC_UPPER] = pulse_upper_limit_fail;
    fail_vec[FC_RATE]  = rate_lower_limit_fail;
  end

  assign fail_any   = |fail_vec;
  assign arm_go     = (state_reg == ST_SAFE) && arm_req && !disarm_req;
  assign ack_go     = (state_reg == ST_FAULT) && fault_ack;
  assign tmr_load   = arm_go || ack_go;
  assign tmr_val    = arm_go ? 32'(ARM_DELAY - 1) : 32'(CLEAR_HOLD - 1);
  assign tmr_dec    = (state_reg == ST_ARMING) || (state_reg == ST_CLEARING);
  assign count_next = (fault_count_reg == 2'd3) ? 2'd3 : fault_count_reg + 2'd1;
  assign fault_dest = ({30'd0, count_next} >= 32'(MAX_FAULTS)) ? ST_LOCKOUT : ST_FAULT;
  assign cfg_ok     = (cfg_wlo != 32'd0) && (cfg_wlo <= cfg_whi) && (cfg_rlo > cfg_whi);

  safety_timer u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg       <= ST_SAFE;
      fault_code_reg  <= '0;
      fault_count_reg <= '0;
      laser_ready_reg <= 1'b0;
      clear_fail_reg  <= 1'b0;
      lockout_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_SAFE: begin
          if (arm_go) state_reg <= ST_ARMING;
        end
        ST_ARMING, ST_ARMED: begin
          // Fail beats disarm; a fault entry may escalate straight to LOCKOUT.
          if (fail_any) begin
            state_reg       <= fault_dest;
            fault_code_reg  <= fault_code_reg | fail_vec;
            fault_count_reg <= count_next;
            lockout_reg     <= (fault_dest == ST_LOCKOUT);
            laser_ready_reg <= 1'b0;
          end else if (disarm_req) begin
            state_reg       <= ST_SAFE;
            laser_ready_reg <= 1'b0;
            if (state_reg == ST_ARMED) fault_count_reg <= '0;
          end else if ((state_reg == ST_ARMING) && tmr_zero) begin
            state_reg       <= ST_ARMED;
            laser_ready_reg <= 1'b1;
          end
        end
        ST_FAULT: begin
          if (fault_ack) begin
            state_reg      <= ST_CLEARING;
            clear_fail_reg <= 1'b1;
          end
        end
        ST_CLEARING: begin
          if (tmr_zero) begin
            clear_fail_reg <= 1'b0;
            if (fail_any) begin
              state_reg      <= ST_FAULT;
              fault_code_reg <= fault_code_reg | fail_vec;
            end else begin
              state_reg      <= ST_SAFE;
              fault_code_reg <= '0;
            end
          end
        end
        ST_LOCKOUT: begin
          lockout_reg <= 1'b1;
        end
        default: state_reg <= ST_SAFE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wlo_reg     <= WLO_DEF;
      whi_reg     <= WHI_DEF;
      rlo_reg     <= RLO_DEF;
      cfg_err_reg <= 1'b0;
    end else begin
      cfg_err_reg <= 1'b0;
      if (cfg_load) begin
        if ((state_reg == ST_SAFE) && cfg_ok) begin
          wlo_reg <= cfg_wlo;
          whi_reg <= cfg_whi;
          rlo_reg <= cfg_rlo;
        end else begin
          cfg_err_reg <= 1'b1;
        end
      end
    end
  end

  assign pulse_width_lower_limit = wlo_reg;
  assign pulse_width_upper_limit = whi_reg;
  assign rate_lower_limit        = rlo_reg;
  assign laser_ready             = laser_ready_reg;
  assign clear_fail              = clear_fail_reg;
  assign ctrl_state              = state_reg;
  assign fault_code              = fault_code_reg;
  assign fault_count             = fault_count_reg;
  assign lockout                 = lockout_reg;
  assign cfg_err                 = cfg_err_reg;

endmodule
